// File: rtl/spram_stream_if.sv
// Stream/command/RAM bundle between the burst controller and its environment.
// slave  : the spram_stream_ctrl side (takes commands, drives the RAM pins).
// master : the command issuer, stream endpoints and the spram instance.
interface spram_stream_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
);
    logic              start;
    logic              dir;
    logic [AWIDTH-1:0] base_addr;
    logic [AWIDTH:0]   len;
    logic              busy;
    logic              done;
    logic [DWIDTH-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [AWIDTH-1:0] ram_address;
    logic              ram_wren;
    logic [DWIDTH-1:0] ram_data;
    logic [DWIDTH-1:0] ram_out;

    modport slave (
        input  start, dir, base_addr, len, in_data, in_valid, out_ready, ram_out,
        output busy, done, in_ready, out_data, out_valid, ram_address, ram_wren, ram_data
    );

    modport master (
        output start, dir, base_addr, len, in_data, in_valid, out_ready, ram_out,
        input  busy, done, in_ready, out_data, out_valid, ram_address, ram_wren, ram_data
    );
endinterface

// File: rtl/spram_stream_ctrl.sv
// Burst sequencer for a single-port RAM with 1-cycle registered read data.
// Write bursts move a valid/ready stream into RAM; read bursts stream RAM
// contents out through a 2-entry buffer sized by a credit rule.
// Optional: define SPRAM_STREAM_PERF_CNT_EN to add the stall_cycles counter.
//
// state | meaning
// IDLE  | waiting for start; len=0 start just pulses done
// WRITE | accepting input words, one RAM write per handshake
// READ  | issuing reads under credit, draining the output buffer
// FIN   | done pulse, back to IDLE next cycle
module spram_stream_ctrl #(
    parameter int AWIDTH    = 10,
    parameter int NUM_WORDS = 1024,
    parameter int DWIDTH    = 32
) (
    input  logic               clk,
    input  logic               resetn,
    spram_stream_if.slave      bus
`ifdef SPRAM_STREAM_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);
    localparam int LWIDTH = AWIDTH + 1;
    localparam logic [LWIDTH-1:0] NUM_WORDS_L = LWIDTH'(NUM_WORDS);
    localparam logic [AWIDTH-1:0] LAST_ADDR   = AWIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, FIN} state_t;

    state_t                   state_q, state_d;
    logic [AWIDTH-1:0]        addr_q, addr_d;
    logic [LWIDTH-1:0]        rem_q, rem_d;
    logic [LWIDTH-1:0]        issue_left_q, issue_left_d;
    logic                     inflight_q, inflight_d;
    logic [1:0][DWIDTH-1:0]   buf_q, buf_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               count_q, count_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [LWIDTH-1:0]        len_clamped;
    logic [AWIDTH-1:0]        addr_inc;
    logic                     in_ready;
    logic                     wr_fire;
    logic                     out_valid;
    logic                     pop;
    logic                     push;
    logic [2:0]               occ;
    logic                     issue;

    // Datapath strobes: handshakes, credit check and wrapped address increment.
    always_comb begin
        len_clamped = (bus.len > NUM_WORDS_L) ? NUM_WORDS_L : bus.len;
        addr_inc    = (addr_q == LAST_ADDR) ? '0 : addr_q + AWIDTH'(1);
        in_ready    = (state_q == WRITE) && (rem_q != '0);
        wr_fire     = in_ready && bus.in_valid;
        out_valid   = (count_q != 2'd0);
        pop         = out_valid && bus.out_ready;
        push        = inflight_q;
        // Occupancy including the word already in flight from the RAM; a pop
        // this cycle frees a slot in time for the capture two edges later.
        occ         = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue       = (state_q == READ) && (issue_left_q != '0) && (occ < 3'd2);
    end

    // Next-state for the FSM, address and burst counters.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        issue_left_d = issue_left_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d       = bus.base_addr;
                        rem_d        = len_clamped;
                        issue_left_d = len_clamped;
                        state_d      = bus.dir ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                if (wr_fire) begin
                    addr_d = addr_inc;
                    rem_d  = rem_q - LWIDTH'(1);
                    if (rem_q == LWIDTH'(1)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    addr_d       = addr_inc;
                    issue_left_d = issue_left_q - LWIDTH'(1);
                end
                if (pop) begin
                    rem_d = rem_q - LWIDTH'(1);
                    if (rem_q == LWIDTH'(1)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d     = (state_d != IDLE);
        inflight_d = issue;
    end

    // Output buffer: capture RAM data one cycle after issue, pop on handshake.
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            buf_d[wr_ptr_q] = bus.ram_out;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // State register; reset abandons any burst and drops buffered data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            issue_left_q <= '0;
            inflight_q   <= 1'b0;
            buf_q        <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            issue_left_q <= issue_left_d;
            inflight_q   <= inflight_d;
            buf_q        <= buf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = buf_q[rd_ptr_q];
    assign bus.ram_wren    = wr_fire;
    assign bus.ram_address = addr_q;
    assign bus.ram_data    = wr_fire ? bus.in_data : '0;

`ifdef SPRAM_STREAM_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Stall counter: idle input stream in WRITE, blocked output in READ.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && bus.start) begin
            stall_d = '0;
        end else if ((((state_q == WRITE) && in_ready && !bus.in_valid) ||
                      ((state_q == READ) && out_valid && !bus.out_ready)) &&
                     (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_spram_stream_ctrl.sv
// Bench for spram_stream_ctrl with a behavioural spram (1-cycle read latency).
module tb_spram_stream_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NW = 1024;
    localparam int LW = AW + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    spram_stream_if #(.AWIDTH(AW), .DWIDTH(DW)) bus();

`ifdef SPRAM_STREAM_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    spram_stream_ctrl #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
`ifdef SPRAM_STREAM_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    logic [DW-1:0] mem [NW];
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
        else              bus.ram_out <= mem[bus.ram_address];
    end

    int n_checks = 0;
    int n_pass   = 0;
    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rd[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.start = 1'b0; bus.dir = 1'b0; bus.base_addr = '0; bus.len = '0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %0b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.ram_wren !== 1'b0) $display("FAIL reset_ram_wren: got %0b want 0", bus.ram_wren); else n_pass++;
        n_checks++; if (bus.ram_address !== '0) $display("FAIL reset_ram_address: got %h want 0", bus.ram_address); else n_pass++;
        n_checks++; if (bus.ram_data !== '0) $display("FAIL reset_ram_data: got %h want 0", bus.ram_data); else n_pass++;
        n_checks++; if (bus.out_data !== '0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else n_pass++;
`ifdef SPRAM_STREAM_PERF_CNT_EN
        n_checks++; if (stall_cycles !== 32'd0) $display("FAIL reset_stall: got %0d want 0", stall_cycles); else n_pass++;
`endif
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_len_zero();
        bus.dir = 1'b1; bus.base_addr = AW'(5); bus.len = '0; bus.in_valid = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b1) $display("FAIL len0_done: got %0b want 1", bus.done); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL len0_busy: got %0b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.ram_wren !== 1'b0) $display("FAIL len0_wren: got %0b want 0", bus.ram_wren); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL len0_in_ready: got %0b want 0", bus.in_ready); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) $display("FAIL len0_done_end: got %0b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL len0_busy_end: got %0b want 0", bus.busy); else n_pass++;
        tick();
    endtask

    task automatic test_write(input logic [AW-1:0] base, input int n, input logic [DW-1:0] d0);
        int  idx = 0;
        int  nwr = 0;
        int  first = -1;
        int  last = -1;
        int  done_cyc = -1;
        bit  hs;
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = AW'((int'(base) + i) % NW);
            e.data = d0 + DW'(i);
            exp_wr.push_back(e);
        end
        bus.dir = 1'b1; bus.base_addr = base; bus.len = LW'(n);
        bus.in_valid = 1'b1; bus.in_data = d0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            if (cyc == 0) begin
                n_checks++; if (bus.busy !== 1'b1) $display("FAIL wr_busy: got %0b want 1", bus.busy); else n_pass++;
            end
            if (bus.ram_wren) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL wr_extra: got write at %h, want none", bus.ram_address);
                end else begin
                    e = exp_wr.pop_front();
                    n_checks++; if (bus.ram_address !== e.addr) $display("FAIL wr_addr: got %h want %h", bus.ram_address, e.addr); else n_pass++;
                    n_checks++; if (bus.ram_data !== e.data) $display("FAIL wr_data: got %h want %h", bus.ram_data, e.data); else n_pass++;
                end
                nwr++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (bus.done) done_cyc = cyc;
            tick();
            if (hs) begin
                idx++;
                bus.in_data = d0 + DW'(idx);
            end
        end
        bus.in_valid = 1'b0;
        n_checks++; if (nwr != n) $display("FAIL wr_count: got %0d want %0d", nwr, n); else n_pass++;
        n_checks++; if (last - first != n - 1) $display("FAIL wr_consecutive: got span %0d want %0d", last - first, n - 1); else n_pass++;
        n_checks++; if (done_cyc != last + 1) $display("FAIL wr_done_cycle: got %0d want %0d", done_cyc, last + 1); else n_pass++;
        n_checks++; if (exp_wr.size() != 0) $display("FAIL wr_missing: got %0d left want 0", exp_wr.size()); else n_pass++;
        exp_wr.delete();
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL wr_after_done: got busy=%0b done=%0b want 0 0", bus.busy, bus.done); else n_pass++;
        tick();
    endtask

    // mode 0: out_ready held 1; mode 1: toggles; mode 2: 0 until cycle 7
    task automatic test_read(input logic [AW-1:0] base, input int n, input logic [DW-1:0] d0, input int mode);
        int npop = 0;
        int nwr = 0;
        int ndone = 0;
        int first_v = -1;
        int last_pop = -1;
        int done_cyc = -1;
        logic [DW-1:0] e;
        for (int i = 0; i < n; i++) exp_rd.push_back(d0 + DW'(i));
        bus.dir = 1'b0; bus.base_addr = base; bus.len = LW'(n); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 60 && done_cyc < 0; cyc++) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 2 == 0);
                default: bus.out_ready = (cyc >= 7);
            endcase
            @(negedge clk);
            if (bus.ram_wren) nwr++;
            if (bus.out_valid && first_v < 0) first_v = cyc;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_extra: got %h want nothing", bus.out_data);
                end else begin
                    e = exp_rd.pop_front();
                    n_checks++; if (bus.out_data !== e) $display("FAIL rd_data: got %h want %h", bus.out_data, e); else n_pass++;
                end
                npop++;
                last_pop = cyc;
            end
            if (bus.done) begin
                done_cyc = cyc;
                ndone++;
`ifdef SPRAM_STREAM_PERF_CNT_EN
                if (mode == 2) begin
                    n_checks++; if (stall_cycles !== 32'd5) $display("FAIL perf_stall: got %0d want 5", stall_cycles); else n_pass++;
                end
`endif
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_checks++; if (npop != n) $display("FAIL rd_count: got %0d want %0d", npop, n); else n_pass++;
        n_checks++; if (exp_rd.size() != 0) $display("FAIL rd_missing: got %0d left want 0", exp_rd.size()); else n_pass++;
        n_checks++; if (done_cyc != last_pop + 1) $display("FAIL rd_done_cycle: got %0d want %0d", done_cyc, last_pop + 1); else n_pass++;
        n_checks++; if (nwr != 0) $display("FAIL rd_wren: got %0d writes want 0", nwr); else n_pass++;
        if (mode == 0) begin
            n_checks++; if (first_v != 2) $display("FAIL rd_latency: got %0d want 2", first_v); else n_pass++;
            n_checks++; if (last_pop - first_v != n - 1) $display("FAIL rd_throughput: got span %0d want %0d", last_pop - first_v, n - 1); else n_pass++;
        end
        exp_rd.delete();
        @(negedge clk);
        if (bus.done) ndone++;
        n_checks++; if (ndone != 1) $display("FAIL rd_done_pulses: got %0d want 1", ndone); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rd_after_done_busy: got %0b want 0", bus.busy); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_read();
        int npop = 0;
        int ndone = 0;
        logic [DW-1:0] e;
        for (int i = 0; i < 8; i++) exp_rd.push_back(32'hB0 + DW'(i));
        bus.dir = 1'b0; bus.base_addr = AW'(16); bus.len = LW'(8); bus.out_ready = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 30 && npop < 3; cyc++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                e = exp_rd.pop_front();
                n_checks++; if (bus.out_data !== e) $display("FAIL rst_rd_data: got %h want %h", bus.out_data, e); else n_pass++;
                npop++;
            end
            tick();
        end
        n_checks++; if (npop != 3) $display("FAIL rst_rd_pops: got %0d want 3", npop); else n_pass++;
        resetn = 1'b0;
        bus.out_ready = 1'b0;
        exp_rd.delete();
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.ram_wren !== 1'b0 || bus.ram_address !== '0 || bus.ram_data !== '0 || bus.out_data !== '0)
            $display("FAIL rst_mid_outputs: got busy=%0b done=%0b ov=%0b ir=%0b wren=%0b addr=%h rd=%h od=%h want all 0",
                     bus.busy, bus.done, bus.out_valid, bus.in_ready, bus.ram_wren, bus.ram_address, bus.ram_data, bus.out_data);
        else n_pass++;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done || bus.out_valid) ndone++;
            tick();
        end
        n_checks++; if (ndone != 0) $display("FAIL rst_no_done: got %0d done/valid cycles want 0", ndone); else n_pass++;
        test_write(AW'(32), 2, 32'hC0);
        test_read(AW'(32), 2, 32'hC0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_len_zero();
        test_write(AW'(10'h3FE), 4, 32'hA0);
        test_read(AW'(10'h3FE), 4, 32'hA0, 0);
        test_write(AW'(16), 8, 32'hB0);
        test_read(AW'(16), 8, 32'hB0, 1);
        test_read(AW'(10'h3FE), 4, 32'hA0, 2);
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spram_stream_ctrl.md
Name: spram_stream_ctrl

Overview:
- Initiator-side sequencer for the single-port RAM wrapper (spram). It drives the RAM's address/wren/data pins and consumes its 1-cycle registered read data.
- Converts a start/base/length command into a sequential burst. Write bursts move data from a valid/ready input stream into RAM. Read bursts move RAM contents to a valid/ready output stream, with backpressure absorbed by a 2-entry output buffer.
- Sits between CoMeFa compute/DMA logic and a spram instance.

Parameters:
AWIDTH, 10, RAM address width
NUM_WORDS, 1024, RAM depth; address wraps at NUM_WORDS-1 -> 0
DWIDTH, 32, data width

Ports:
clk  input  1  clock, all logic on posedge
resetn  input  1  synchronous active-low reset
start  input  1  command strobe, sampled only in IDLE
dir  input  1  0 = read burst, 1 = write burst
base_addr  input  AWIDTH  first word address
len  input  AWIDTH+1  word count, 0..NUM_WORDS
busy  output  1  high from the cycle after an accepted start until done
done  output  1  1-cycle pulse at burst completion
in_data  input  DWIDTH  write stream data
in_valid  input  1  write stream valid
in_ready  output  1  write stream ready
out_data  output  DWIDTH  read stream data (head of buffer)
out_valid  output  1  read stream valid
out_ready  input  1  read stream ready
ram_address  output  AWIDTH  to spram address
ram_wren  output  1  to spram wren
ram_data  output  DWIDTH  to spram data
ram_out  input  DWIDTH  from spram out, valid the cycle after a read issue

Behaviour:
- Reset (resetn=0 at posedge) forces:
  - state IDLE; busy=0, done=0, in_ready=0, out_valid=0;
  - ram_wren=0, ram_address=0, ram_data=0, out_data=0;
  - buffer and counters cleared.
  - Reset mid-burst abandons the burst: no done pulse, buffered read data discarded.
- States: IDLE, WRITE, READ, FIN.
- IDLE:
  - start=1 with len=0 -> done pulses next cycle; busy never rises.
  - start=1 with len>0 latches addr=base_addr and remaining=len, then moves to WRITE (dir=1) or READ (dir=0).
  - start while busy is ignored.
- WRITE:
  - in_ready=1 combinationally while remaining>0.
  - Each in_valid&in_ready handshake drives ram_wren=1, ram_address=addr, ram_data=in_data in the same cycle (combinational drive; RAM samples at that edge).
  - Then addr advances and remaining decrements.
  - ram_wren=0 on cycles without a handshake.
  - The handshake that takes remaining to 0 moves the block to FIN.
- READ:
  - Read issue: ram_wren=0, ram_address=addr. The data is captured from ram_out exactly one cycle later into the buffer.
  - Credit rule: issue only when (buf_count + inflight - pop_this_cycle) < 2. This guarantees no overflow and sustains 1 word/cycle while out_ready=1.
  - issued counter stops at len. Moves to FIN when all len words have been popped.
- Buffer: 2-entry FIFO. out_valid = buf_count>0; pop = out_valid&out_ready. Push and pop in the same cycle are legal.
- FIN: done=1 for one cycle, busy=0 the next cycle, return to IDLE. A start is accepted the following cycle.
- busy=1 in WRITE, READ and FIN.
- Address wrap: addr==NUM_WORDS-1 increments to 0. Arithmetic is modulo NUM_WORDS, not 2^AWIDTH.
- len>NUM_WORDS is clamped to NUM_WORDS.
- The RAM holds out during writes; the controller never reads ram_out except in the capture cycle.

Optional Feature:
- Macro SPRAM_STREAM_PERF_CNT_EN.
- Defined:
  - Adds output port stall_cycles [31:0].
  - Counts cycles in WRITE with in_ready&!in_valid, plus cycles in READ with out_valid&!out_ready.
  - Cleared on reset and on each accepted start; saturates at 2^32-1; holds its value in IDLE.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Write len=4, base=0x3FE, in_valid held 1, data 0xA0..0xA3 -> writes land at 0x3FE, 0x3FF, 0x000, 0x001 on 4 consecutive cycles; done one cycle after the last write.
- Read len=4, base=0x3FE, out_ready=1 -> out_data 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles; first out_valid 2 cycles after start.
- Read len=8, out_ready toggles 1/0 every cycle -> no data lost or duplicated, buffer never exceeds 2 entries, 8 words returned in order, single done pulse.
- start with len=0 -> done pulses next cycle, busy stays 0, no RAM access.
- resetn=0 mid read burst after 3 of 8 words -> all outputs 0 the next cycle, no done; a new write burst of len=2 afterwards completes normally.
- With SPRAM_STREAM_PERF_CNT_EN defined: read len=4, out_ready held 0 for 5 cycles after the first out_valid -> stall_cycles=5 at done.
